// File: rtl/i2c_config_seq.sv
// I2C register-programming sequencer: walks a table ROM and issues one 3-byte write per entry with NACK retry.
// Build option HPD_REINIT_EN: reprogram the whole table on a rising edge of interrupt.
module i2c_config_seq #(
  parameter logic [7:0]  DEVICE_ADDR = 8'h7A,
  parameter int unsigned TABLE_DEPTH = 25,
  parameter int unsigned INDEX_WIDTH = 8,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned BOOT_DELAY  = 16
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic                   interrupt,
  output logic [INDEX_WIDTH-1:0] table_index,
  input  logic [15:0]            table_data,
  output logic                   i2c_start,
  output logic [23:0]            i2c_data,
  input  logic                   i2c_stop,
  input  logic                   i2c_ack,
  output logic                   busy,
  output logic                   config_done,
  output logic                   config_error,
  output logic [INDEX_WIDTH-1:0] error_index
);

  localparam int unsigned BOOT_W = $clog2(BOOT_DELAY + 1) + 1;
  localparam logic [BOOT_W-1:0]      BOOT_LAST   = BOOT_W'(BOOT_DELAY);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(TABLE_DEPTH - 1);
  localparam logic [3:0]             RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_ISSUE, ST_WAIT, ST_RELEASE, ST_NEXT, ST_DONE, ST_ERROR
  } state_t;

  state_t                 state, state_d;
  logic [BOOT_W-1:0]      boot_cnt, boot_cnt_d;
  logic [INDEX_WIDTH-1:0] index_d, error_index_d;
  logic [3:0]             retries, retries_d;
  logic                   ack_q, ack_d;
  logic                   start_d;
  logic [23:0]            data_d;
  logic                   reinit_c;
  logic                   terminal_c;

  assign terminal_c = (state == ST_DONE) || (state == ST_ERROR);

`ifdef HPD_REINIT_EN
  logic interrupt_q;
  logic pending, pending_d;
  logic irq_edge_c;

  assign irq_edge_c = interrupt & ~interrupt_q;
  assign reinit_c   = terminal_c & (irq_edge_c | pending);

  // An edge during an active run is remembered and served once the run ends.
  always_comb begin
    pending_d = pending;
    if (terminal_c)      pending_d = 1'b0;
    else if (irq_edge_c) pending_d = 1'b1;
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      interrupt_q <= 1'b0;
      pending     <= 1'b0;
    end else begin
      interrupt_q <= interrupt;
      pending     <= pending_d;
    end
  end
`else
  logic unused_interrupt;
  assign unused_interrupt = interrupt;
  assign reinit_c         = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    boot_cnt_d    = boot_cnt;
    index_d       = table_index;
    retries_d     = retries;
    ack_d         = ack_q;
    start_d       = i2c_start;
    data_d        = i2c_data;
    error_index_d = error_index;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_d   = ST_FETCH;
          index_d   = '0;
          retries_d = '0;
        end else begin
          boot_cnt_d = boot_cnt + BOOT_W'(1);
        end
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        data_d  = {DEVICE_ADDR, table_data};
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i2c_stop) begin
          ack_d   = i2c_ack;
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!i2c_stop) begin
          if (!ack_q) begin
            state_d = ST_NEXT;
          end else if (retries < RETRY_LIMIT) begin
            retries_d = retries + 4'd1;
            state_d   = ST_ISSUE;
          end else begin
            error_index_d = table_index;
            state_d       = ST_ERROR;
          end
        end
      end
      ST_NEXT: begin
        if (table_index == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          index_d   = table_index + INDEX_WIDTH'(1);
          retries_d = '0;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        if (reinit_c) begin
          index_d   = '0;
          retries_d = '0;
          state_d   = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state        <= ST_BOOT;
      boot_cnt     <= '0;
      table_index  <= '0;
      retries      <= '0;
      ack_q        <= 1'b0;
      i2c_start    <= 1'b0;
      i2c_data     <= '0;
      busy         <= 1'b0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      error_index  <= '0;
    end else begin
      state        <= state_d;
      boot_cnt     <= boot_cnt_d;
      table_index  <= index_d;
      retries      <= retries_d;
      ack_q        <= ack_d;
      i2c_start    <= start_d;
      i2c_data     <= data_d;
      busy         <= (state_d != ST_BOOT) && (state_d != ST_DONE) && (state_d != ST_ERROR);
      config_done  <= (state_d == ST_DONE);
      config_error <= (state_d == ST_ERROR);
      error_index  <= error_index_d;
    end
  end

endmodule
